// File: rtl/hc595_frame_serializer_if.sv
// Frame handshake and 74HC595 pin bundle between the display multiplexer and the serializer.
// The multiplexer side uses the master modport and the serializer uses the slave modport.
interface hc595_frame_serializer_if #(
  parameter int N = 16
);
  logic         start_i;
  logic [N-1:0] data_i;
  logic         ready_o;
  logic         done_o;
  logic         sclk_o;
  logic         data_o;
  logic         latch_en_o;

  modport master (
    output start_i, data_i,
    input  ready_o, done_o, sclk_o, data_o, latch_en_o
  );

  modport slave (
    input  start_i, data_i,
    output ready_o, done_o, sclk_o, data_o, latch_en_o
  );
endinterface

// File: rtl/hc595_frame_serializer.sv
// Shifts one parallel frame into a chain of NUM_ICS 74HC595s, then pulses ST_CP.
// Optional macro HC595_LSB_FIRST_EN selects LSB-first shifting; the default is MSB-first.
module hc595_frame_serializer #(
  parameter int NUM_ICS    = 2,
  parameter int CLK_DIV    = 4,
  parameter int IDLE_LATCH = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  hc595_frame_serializer_if.slave   bus
);
  localparam int N  = 8 * NUM_ICS;
  localparam int PW = ($clog2(2 * CLK_DIV) > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = $clog2(N + 1);

  localparam logic [PW-1:0] PH_HI    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic          IDLE_LVL = 1'(IDLE_LATCH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t        state_r;
  logic [N-1:0]  sr_r;
  logic [BW-1:0] bit_cnt_r;
  logic [PW-1:0] phase_r;

  // Bit that goes onto DS next, taken from the head of the frame.
  function automatic logic head_bit(input logic [N-1:0] f);
`ifdef HC595_LSB_FIRST_EN
    return f[0];
`else
    return f[N-1];
`endif
  endfunction

  // Frame with its head bit consumed.
  function automatic logic [N-1:0] advance(input logic [N-1:0] f);
`ifdef HC595_LSB_FIRST_EN
    return {1'b0, f[N-1:1]};
`else
    return {f[N-2:0], 1'b0};
`endif
  endfunction

  // Frame FSM: DS changes only where SH_CP falls, so setup and hold are both CLK_DIV cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= ST_IDLE;
      sr_r           <= '0;
      bit_cnt_r      <= '0;
      phase_r        <= '0;
      bus.ready_o    <= 1'b1;
      bus.done_o     <= 1'b0;
      bus.sclk_o     <= 1'b0;
      bus.data_o     <= 1'b0;
      bus.latch_en_o <= IDLE_LVL;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus.done_o <= 1'b0;
          if (bus.start_i) begin
            sr_r        <= advance(bus.data_i);
            bus.data_o  <= head_bit(bus.data_i);
            bus.ready_o <= 1'b0;
            bus.sclk_o  <= 1'b0;
            bit_cnt_r   <= '0;
            phase_r     <= '0;
            state_r     <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (phase_r == PH_LAST) begin
            phase_r    <= '0;
            bus.sclk_o <= 1'b0;
            if (bit_cnt_r == BIT_LAST) begin
              bus.latch_en_o <= 1'b1;
              state_r        <= ST_LATCH;
            end else begin
              bit_cnt_r  <= bit_cnt_r + BW'(1);
              bus.data_o <= head_bit(sr_r);
              sr_r       <= advance(sr_r);
            end
          end else begin
            phase_r <= phase_r + PW'(1);
            if (phase_r == PH_HI) begin
              bus.sclk_o <= 1'b1;
            end else begin
              bus.sclk_o <= bus.sclk_o;
            end
          end
        end
        ST_LATCH: begin
          // Latch pulse reuses the phase counter; done and ready rise together as it ends.
          if (phase_r == PH_HI) begin
            phase_r        <= '0;
            bus.latch_en_o <= IDLE_LVL;
            bus.done_o     <= 1'b1;
            bus.ready_o    <= 1'b1;
            state_r        <= ST_IDLE;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          phase_r        <= '0;
          bit_cnt_r      <= '0;
          bus.ready_o    <= 1'b1;
          bus.done_o     <= 1'b0;
          bus.sclk_o     <= 1'b0;
          bus.latch_en_o <= IDLE_LVL;
        end
      endcase
    end
  end
endmodule
